pedal_chain_sequencer: RTL and testbench

- Per-sample scheduler for the effect chain.
- Accepts one audio sample per codec strobe and runs it through up to NUM_STAGES effect pedals in fixed order. Each stage uses a START/Done handshake; the sample is routed over one shared data bus.
- Pedals whose enable switch is low are skipped.
- Presents the final sample to the codec output with a one-cycle valid strobe.
- Sits between the codec interface and the effect pedal instances (overdrive, compressor, looper, reverb).

---
 rtl/pedal_chain_sequencer.sv | 149 ++++++++++++++
 tb/tb_pedal_chain_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pedal_chain_sequencer.sv
// Per-sample scheduler that walks one codec sample through the enabled effect pedals over a shared bus.
// Optional stage watchdog with sticky per-stage fault flags: define PEDAL_SEQ_TIMEOUT_EN.
module pedal_chain_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Sample_valid,
  input  logic [DATA_W-1:0]            Signal_in,
  input  logic [NUM_STAGES-1:0]        Stage_en,
  output logic [NUM_STAGES-1:0]        Stage_start,
  output logic [DATA_W-1:0]            Stage_in,
  input  logic [NUM_STAGES-1:0]        Stage_done,
  input  logic [NUM_STAGES*DATA_W-1:0] Stage_out,
  output logic [DATA_W-1:0]            Signal_out,
  output logic                         Out_valid,
  output logic                         Busy,
  output logic                         Overrun,
  output logic [NUM_STAGES-1:0]        Stage_fault
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int PTR_W = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, RUN, OUT} state_t;

  state_t                  state_q;
  logic [DATA_W-1:0]       data_q;
  logic [DATA_W-1:0]       sig_out_q;
  logic [NUM_STAGES-1:0]   en_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        cur_q;
  logic                    out_valid_q;
  logic                    overrun_q;
  logic                    scan_found;
  logic [IDX_W-1:0]        scan_idx;
  logic [PTR_W-1:0]        ptr_d;

  // Lowest enabled stage at or above ptr; descending loop so the lowest match wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (en_q[i] && (i >= int'(ptr_q))) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(i);
      end
    end
  end

  assign ptr_d = PTR_W'(cur_q) + PTR_W'(1);

`ifdef PEDAL_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0]      tmo_q;
  logic [NUM_STAGES-1:0] fault_q;
  logic                  tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
    if (!Reset_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      sig_out_q   <= '0;
      en_q        <= '0;
      ptr_q       <= '0;
      cur_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PEDAL_SEQ_TIMEOUT_EN
      tmo_q       <= '0;
      fault_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge register values.
      out_valid_q <= 1'b0;
      if (Sample_valid && (state_q != IDLE)) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (Sample_valid) begin
            data_q  <= Signal_in;
            en_q    <= Stage_en;
            ptr_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (scan_found) begin
            cur_q   <= scan_idx;
            state_q <= RUN;
`ifdef PEDAL_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end else begin
            state_q <= OUT;
          end
        end
        RUN: begin
          if (Stage_done[cur_q]) begin
            data_q  <= Stage_out[int'(cur_q)*DATA_W +: DATA_W];
            ptr_q   <= ptr_d;
            state_q <= SCAN;
          end
`ifdef PEDAL_SEQ_TIMEOUT_EN
          // A stalled pedal is bypassed: the sample passes through unchanged.
          else if (tmo_hit) begin
            fault_q[cur_q] <= 1'b1;
            ptr_q          <= ptr_d;
            state_q        <= SCAN;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        OUT: begin
          sig_out_q   <= data_q;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Start is a pure decode of registered state, so it cannot glitch.
  always_comb begin
    Stage_start = '0;
    if (state_q == RUN) Stage_start[cur_q] = 1'b1;
  end

  assign Stage_in   = data_q;
  assign Signal_out = sig_out_q;
  assign Out_valid  = out_valid_q;
  assign Busy       = (state_q != IDLE);
  assign Overrun    = overrun_q;

`ifdef PEDAL_SEQ_TIMEOUT_EN
  assign Stage_fault = fault_q;
`else
  assign Stage_fault = '0;
`endif

endmodule

// File: tb/tb_pedal_chain_sequencer.sv
// Directed bench for pedal_chain_sequencer with behavioural pedal models (out = in*MUL + ADD after LAT cycles).
module tb_pedal_chain_sequencer;

  localparam int NS = 4;
  localparam int DW = 16;
  localparam int MUL [NS] = '{1, 1, 2, 1};
  localparam int ADD [NS] = '{1, 100, 0, 7};

  logic           Clk = 1'b0;
  logic           Reset_n;
  logic           Sample_valid;
  logic [DW-1:0]  Signal_in;
  logic [NS-1:0]  Stage_en;
  logic [NS-1:0]  Stage_start;
  logic [DW-1:0]  Stage_in;
  logic [NS-1:0]  Stage_done;
  logic [NS*DW-1:0] Stage_out;
  logic [DW-1:0]  Signal_out;
  logic           Out_valid;
  logic           Busy;
  logic           Overrun;
  logic [NS-1:0]  Stage_fault;

  int n_vec = 0;
  int n_err = 0;

  int lat [NS];
  int cnt [NS];
  logic [NS-1:0] ever_start;
  logic          clr_ever;

  pedal_chain_sequencer #(.NUM_STAGES(NS), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Sample_valid(Sample_valid), .Signal_in(Signal_in),
    .Stage_en(Stage_en), .Stage_start(Stage_start), .Stage_in(Stage_in),
    .Stage_done(Stage_done), .Stage_out(Stage_out), .Signal_out(Signal_out),
    .Out_valid(Out_valid), .Busy(Busy), .Overrun(Overrun), .Stage_fault(Stage_fault)
  );

  always #5 Clk = ~Clk;

  // Pedal models: Done in the LAT-th cycle of Start; LAT of 0 never answers.
  always @(posedge Clk) begin
    for (int i = 0; i < NS; i++) cnt[i] <= Stage_start[i] ? cnt[i] + 1 : 0;
    ever_start <= clr_ever ? '0 : (ever_start | Stage_start);
  end

  always_comb begin
    Stage_done = '0;
    Stage_out  = '0;
    for (int i = 0; i < NS; i++) begin
      Stage_done[i] = Stage_start[i] && (lat[i] != 0) && (cnt[i] == lat[i] - 1);
      Stage_out[i*DW +: DW] = DW'(int'(Stage_in) * MUL[i] + ADD[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle; returns at the negedge of the first SCAN cycle.
  task automatic send(input logic [DW-1:0] s, input logic [NS-1:0] en);
    Sample_valid = 1'b1;
    Signal_in    = s;
    Stage_en     = en;
    @(negedge Clk);
    Sample_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic wait_out(input int budget, output int k);
    k = 0;
    while (!Out_valid && k < budget) begin
      @(negedge Clk);
      k++;
    end
  endtask

  task automatic clear_starts();
    clr_ever = 1'b1;
    @(negedge Clk);
    clr_ever = 1'b0;
  endtask

  initial begin
    int k;
    int pulses;
    lat          = '{3, 2, 2, 3};
    clr_ever     = 1'b1;
    Reset_n      = 1'b0;
    Sample_valid = 1'b0;
    Signal_in    = '0;
    Stage_en     = '0;
    step(3);
    Reset_n  = 1'b1;
    clr_ever = 1'b0;

    // Reset state
    check("rst_start",   32'(Stage_start), 32'h0);
    check("rst_stage_in", 32'(Stage_in),   32'h0);
    check("rst_sig_out", 32'(Signal_out),  32'h0);
    check("rst_valid",   32'(Out_valid),   32'h0);
    check("rst_busy",    32'(Busy),        32'h0);
    check("rst_overrun", 32'(Overrun),     32'h0);
    check("rst_fault",   32'(Stage_fault), 32'h0);

    // All stages bypassed: Out_valid at t+3 carrying the raw sample
    send(16'h1234, 4'b0000);
    check("byp_busy1",  32'(Busy),      32'h1);
    check("byp_valid1", 32'(Out_valid), 32'h0);
    step(1);
    check("byp_busy2",  32'(Busy),      32'h1);
    check("byp_valid2", 32'(Out_valid), 32'h0);
    step(1);
    check("byp_valid3", 32'(Out_valid),  32'h1);
    check("byp_data",   32'(Signal_out), 32'h1234);
    step(1);
    check("byp_pulse",  32'(Out_valid),  32'h0);
    check("byp_hold",   32'(Signal_out), 32'h1234);
    check("byp_starts", 32'(ever_start), 32'h0);

    // Stages 0 and 2: (10+1)*2 = 22, latency t+3 + (3+1) + (2+1)
    clear_starts();
    send(16'd10, 4'b0101);
    check("s02_scan_start", 32'(Stage_start), 32'h0);
    step(1);
    check("s02_run_start", 32'(Stage_start), 32'h1);
    check("s02_bus",       32'(Stage_in),    32'd10);
    wait_out(50, k);
    check("s02_latency", 32'(k),          32'd8);
    check("s02_data",    32'(Signal_out), 32'd22);
    step(1);
    check("s02_pulse",   32'(Out_valid),  32'h0);
    check("s02_starts",  32'(ever_start), 32'h5);

    // Overrun: second strobe during RUN of stage 0 is dropped
    send(16'd5, 4'b0001);
    step(1);
    send(16'd999, 4'b0001);
    check("ovr_flag", 32'(Overrun), 32'h1);
    wait_out(50, k);
    check("ovr_latency", 32'(k),          32'd4);
    check("ovr_data",    32'(Signal_out), 32'd6);
    step(2);
    send(16'd20, 4'b0001);
    wait_out(50, k);
    check("ovr_next_lat",  32'(k),          32'd6);
    check("ovr_next_data", 32'(Signal_out), 32'd21);
    check("ovr_sticky",    32'(Overrun),    32'h1);

    // Enable change mid-sample only affects the following sample
    step(1);
    clear_starts();
    send(16'd30, 4'b0001);
    step(1);
    Stage_en = 4'b0011;
    wait_out(50, k);
    check("en_frozen_lat",  32'(k),          32'd5);
    check("en_frozen_data", 32'(Signal_out), 32'd31);
    check("en_frozen_st",   32'(ever_start), 32'h1);
    step(1);
    send(16'd30, 4'b0011);
    wait_out(50, k);
    check("en_new_lat",  32'(k),          32'd9);
    check("en_new_data", 32'(Signal_out), 32'd131);

    // One-cycle reset during RUN of stage 1 abandons the sample
    step(1);
    send(16'd40, 4'b0011);
    step(5);
    check("mid_in_run1", 32'(Stage_start), 32'h2);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("mid_start",   32'(Stage_start), 32'h0);
    check("mid_busy",    32'(Busy),        32'h0);
    check("mid_sig_out", 32'(Signal_out),  32'h0);
    check("mid_bus",     32'(Stage_in),    32'h0);
    check("mid_overrun", 32'(Overrun),     32'h0);
    check("mid_valid",   32'(Out_valid),   32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Out_valid) pulses++;
    end
    check("mid_no_out", 32'(pulses), 32'h0);
    send(16'd50, 4'b0011);
    wait_out(50, k);
    check("mid_next_lat",  32'(k),          32'd9);
    check("mid_next_data", 32'(Signal_out), 32'd151);

`ifdef PEDAL_SEQ_TIMEOUT_EN
    // Stage 0 never answers: bypassed after 8 RUN cycles
    step(1);
    lat[0] = 0;
    send(16'h00AA, 4'b0001);
    step(8);
    check("tmo_pre_fault", 32'(Stage_fault), 32'h0);
    wait_out(50, k);
    check("tmo_latency", 32'(k),           32'd3);
    check("tmo_fault",   32'(Stage_fault), 32'h1);
    check("tmo_data",    32'(Signal_out),  32'h00AA);
    lat[0] = 3;
`else
    check("no_tmo_fault", 32'(Stage_fault), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
